// File: rtl/acc_sequencer.sv
// Fetch/decode/execute sequencer for the 11-bit accumulator ALU: owns pc, acc,
// jump decisions and the sleep timer, and saturates every acc write to +/-999.
module acc_sequencer #(
  parameter int PC_W  = 6,
  parameter int SLP_W = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [PC_W-1:0] prog_addr,
  input  logic [25:0]     prog_data,
  output logic [3:0]      alu_inst,
  output logic [10:0]     alu_arg1,
  output logic [10:0]     alu_arg2,
  output logic [10:0]     alu_acc,
  input  logic [10:0]     alu_out,
  output logic [10:0]     acc,
  output logic [PC_W-1:0] pc,
  output logic            sleeping,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_SLEEP  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_JMP = 4'd2;
  localparam logic [3:0] OP_SLP = 4'd3;
  localparam logic [3:0] OP_JEZ = 4'd4;
  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;

  localparam logic signed [10:0] SAT_MAX = 11'sd999;
  localparam logic signed [10:0] SAT_MIN = -11'sd999;
  localparam logic [PC_W-1:0]    PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [SLP_W-1:0]   SLP_ONE = {{(SLP_W-1){1'b0}}, 1'b1};

  // Signed clamp of an 11-bit value into [-999, +999].
  function automatic logic [10:0] sat11(input logic [10:0] x);
    logic [10:0] r;
    if ($signed(x) > SAT_MAX) begin
      r = SAT_MAX;
    end else if ($signed(x) < SAT_MIN) begin
      r = SAT_MIN;
    end else begin
      r = x;
    end
    return r;
  endfunction

  state_t           state_r;
  // arg2 only ever feeds the ALU, so ir keeps opcode and arg1 for decode.
  logic [14:0]      ir_r;
  logic [10:0]      acc_r;
  logic [PC_W-1:0]  pc_r;
  logic [SLP_W-1:0] slp_cnt_r;
  logic [3:0]       alu_inst_r;
  logic [10:0]      alu_arg1_r;
  logic [10:0]      alu_arg2_r;
  logic             sleeping_r;
  logic             busy_r;

  logic [3:0]       op_s;
  logic [10:0]      arg1_s;
  logic [PC_W-1:0]  pc_inc_s;
  logic [PC_W-1:0]  pc_next_s;
  logic [10:0]      acc_next_s;
  logic             acc_we_s;
  logic             slp_go_s;
  logic [SLP_W-1:0] slp_load_s;

  assign op_s     = ir_r[14:11];
  assign arg1_s   = ir_r[10:0];
  assign pc_inc_s = pc_r + PC_ONE;

  // Execute-stage decode: next pc, acc write and sleep entry for the held instruction.
  always_comb begin
    pc_next_s  = pc_inc_s;
    acc_next_s = acc_r;
    acc_we_s   = 1'b0;
    slp_go_s   = 1'b0;
    slp_load_s = SLP_W'(arg1_s) - SLP_ONE;
    case (op_s)
      OP_NOP: begin
        pc_next_s = pc_inc_s;
      end
      OP_MOV: begin
        acc_we_s   = 1'b1;
        acc_next_s = sat11(arg1_s);
      end
      OP_JMP: begin
        pc_next_s = arg1_s[PC_W-1:0];
      end
      OP_SLP: begin
        // Non-positive sleep lengths degrade to nop.
        if ($signed(arg1_s) > 11'sd0) begin
          slp_go_s = 1'b1;
        end else begin
          slp_go_s = 1'b0;
        end
      end
      OP_JEZ: begin
        if (acc_r == 11'd0) begin
          pc_next_s = arg1_s[PC_W-1:0];
        end else begin
          pc_next_s = pc_inc_s;
        end
      end
      OP_ADD, OP_SUB, OP_MUL, OP_NOT: begin
        acc_we_s   = 1'b1;
        acc_next_s = sat11(alu_out);
      end
      default: begin
        pc_next_s = pc_inc_s;
      end
    endcase
  end

  // Sequencer state machine with registered ALU drive and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_FETCH;
      ir_r       <= 15'd0;
      acc_r      <= 11'd0;
      pc_r       <= {PC_W{1'b0}};
      slp_cnt_r  <= {SLP_W{1'b0}};
      alu_inst_r <= 4'd0;
      alu_arg1_r <= 11'd0;
      alu_arg2_r <= 11'd0;
      sleeping_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (run) begin
            state_r <= S_DECODE;
            busy_r  <= 1'b1;
          end else begin
            state_r <= S_FETCH;
            busy_r  <= 1'b0;
          end
        end
        S_DECODE: begin
          ir_r       <= prog_data[25:11];
          alu_inst_r <= prog_data[25:22];
          alu_arg1_r <= prog_data[21:11];
          alu_arg2_r <= prog_data[10:0];
          state_r    <= S_EXEC;
          busy_r     <= 1'b1;
        end
        S_EXEC: begin
          alu_inst_r <= 4'd0;
          alu_arg1_r <= 11'd0;
          alu_arg2_r <= 11'd0;
          pc_r       <= pc_next_s;
          if (acc_we_s) begin
            acc_r <= acc_next_s;
          end else begin
            acc_r <= acc_r;
          end
          if (slp_go_s) begin
            slp_cnt_r  <= slp_load_s;
            state_r    <= S_SLEEP;
            sleeping_r <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= S_FETCH;
            sleeping_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        S_SLEEP: begin
          // Counter was loaded with N-1, so SLEEP lasts exactly N cycles.
          if (slp_cnt_r == {SLP_W{1'b0}}) begin
            state_r    <= S_FETCH;
            sleeping_r <= 1'b0;
            busy_r     <= 1'b0;
          end else begin
            slp_cnt_r  <= slp_cnt_r - SLP_ONE;
            sleeping_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        default: begin
          state_r    <= S_FETCH;
          alu_inst_r <= 4'd0;
          alu_arg1_r <= 11'd0;
          alu_arg2_r <= 11'd0;
          sleeping_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign prog_addr = pc_r;
  assign pc        = pc_r;
  assign acc       = acc_r;
  assign alu_acc   = acc_r;
  assign alu_inst  = alu_inst_r;
  assign alu_arg1  = alu_arg1_r;
  assign alu_arg2  = alu_arg2_r;
  assign sleeping  = sleeping_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer: synchronous program ROM, a stub ALU with an
// override for saturation corners, and hand-computed expectations.
module tb_acc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [5:0]  prog_addr;
  logic [25:0] prog_data;
  logic [3:0]  alu_inst;
  logic [10:0] alu_arg1;
  logic [10:0] alu_arg2;
  logic [10:0] alu_acc;
  logic [10:0] alu_out;
  logic [10:0] acc;
  logic [5:0]  pc;
  logic        sleeping;
  logic        busy;

  logic [25:0] mem [0:63];
  logic        force_en;
  logic [10:0] force_val;
  logic [10:0] alu_calc;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  acc_sequencer #(.PC_W(6), .SLP_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .alu_inst(alu_inst), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2),
    .alu_acc(alu_acc), .alu_out(alu_out),
    .acc(acc), .pc(pc), .sleeping(sleeping), .busy(busy)
  );

  always @(posedge clk) prog_data <= mem[prog_addr];

  always_comb begin
    case (alu_inst)
      4'd5:    alu_calc = alu_acc + alu_arg1;
      4'd6:    alu_calc = alu_acc - alu_arg1;
      4'd7:    alu_calc = alu_acc * alu_arg1;
      4'd8:    alu_calc = ~alu_acc;
      default: alu_calc = alu_acc;
    endcase
    alu_out = force_en ? force_val : alu_calc;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr3();
    step(); step(); step();
  endtask

  function automatic logic [25:0] ins(input logic [3:0] op, input int a1, input int a2);
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = a1;
    t2 = a2;
    return {op, t1[10:0], t2[10:0]};
  endfunction

  initial begin
    rst_n = 1'b0; run = 1'b0; force_en = 1'b0; force_val = 11'd0;
    for (int i = 0; i < 64; i++) mem[i] = 26'd0;
    mem[0]  = ins(4'd1, 5, 0);      // mov 5
    mem[1]  = ins(4'd5, 3, 77);     // add 3
    mem[2]  = ins(4'd0, 0, 0);      // nop
    mem[3]  = ins(4'd1, 900, 0);    // mov 900
    mem[4]  = ins(4'd5, 500, 0);    // add 500 -> wraps to -648
    mem[5]  = ins(4'd5, 0, 0);      // forced ALU results
    mem[6]  = ins(4'd5, 0, 0);
    mem[7]  = ins(4'd5, 0, 0);
    mem[8]  = ins(4'd1, 0, 0);      // mov 0
    mem[9]  = ins(4'd4, 20, 0);     // jez 20, taken
    mem[20] = ins(4'd1, 1, 0);      // mov 1
    mem[21] = ins(4'd4, 0, 0);      // jez 0, not taken
    mem[22] = ins(4'd3, 4, 0);      // slp 4
    mem[23] = ins(4'd3, 0, 0);      // slp 0
    mem[24] = ins(4'd3, -3, 0);     // slp -3
    mem[25] = ins(4'd1, 1000, 0);   // mov 1000 -> 999
    mem[26] = ins(4'd1, -1000, 0);  // mov -1000 -> -999
    mem[27] = ins(4'd6, 5, 0);      // sub 5 -> -1004 -> -999
    mem[28] = ins(4'd9, 7, 0);      // reserved
    mem[29] = ins(4'd1, 7, 0);      // mov 7
    mem[30] = ins(4'd7, 3, 0);      // mul 3 -> 21
    mem[31] = ins(4'd8, 0, 0);      // not -> -22
    mem[32] = ins(4'd2, -1, 0);     // jmp -1 -> 63
    mem[63] = ins(4'd0, 0, 0);      // nop at last address

    step(); step();
    chk("rst_acc", $signed(acc), 0);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sleeping", sleeping, 0);
    chk("rst_alu_inst", alu_inst, 0);
    chk("rst_alu_arg1", alu_arg1, 0);
    chk("rst_alu_arg2", alu_arg2, 0);
    rst_n = 1'b1; run = 1'b1;

    step(); chk("mov5_decode_busy", busy, 1);
    step(); chk("mov5_exec_inst", alu_inst, 1); chk("mov5_exec_arg1", alu_arg1, 5);
    step(); chk("mov5_acc", $signed(acc), 5); chk("mov5_pc", pc, 1); chk("mov5_fetch_busy", busy, 0);
    step(); chk("add3_fetch_inst", alu_inst, 0);
    step(); chk("add3_exec_inst", alu_inst, 5); chk("add3_exec_arg2", alu_arg2, 77);
    step(); chk("add3_acc", $signed(acc), 8); chk("add3_alu_acc", $signed(alu_acc), 8);
    instr3(); chk("nop_pc", pc, 3); chk("nop_acc", $signed(acc), 8);
    instr3(); chk("mov900_acc", $signed(acc), 900);
    instr3(); chk("add500_wrap_acc", $signed(acc), -648);
    force_en = 1'b1; force_val = 11'd999;
    instr3(); chk("sat_999", $signed(acc), 999);
    force_val = 11'd1048;  // -1000 in 11 bits
    instr3(); chk("sat_m1000", $signed(acc), -999);
    force_val = 11'd1023;
    instr3(); chk("sat_1023", $signed(acc), 999);
    force_en = 1'b0;
    instr3(); chk("mov0_acc", $signed(acc), 0);
    instr3(); chk("jez_taken_pc", pc, 20);
    instr3(); chk("mov1_acc", $signed(acc), 1);
    instr3(); chk("jez_not_taken_pc", pc, 22);

    step(); step(); chk("slp4_exec_sleeping", sleeping, 0); chk("slp4_exec_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      step(); chk("slp4_sleeping", sleeping, 1); chk("slp4_busy", busy, 1);
    end
    step(); chk("slp4_wake_sleeping", sleeping, 0); chk("slp4_wake_busy", busy, 0);
    chk("slp4_prog_addr", prog_addr, 23);
    for (int k = 0; k < 3; k++) begin
      step(); chk("slp0_no_sleep", sleeping, 0);
    end
    chk("slp0_pc", pc, 24);
    for (int k = 0; k < 3; k++) begin
      step(); chk("slpm3_no_sleep", sleeping, 0);
    end
    chk("slpm3_pc", pc, 25); chk("slpm3_busy", busy, 0);

    instr3(); chk("mov1000_sat", $signed(acc), 999);
    instr3(); chk("movm1000_sat", $signed(acc), -999);
    instr3(); chk("sub_sat", $signed(acc), -999);
    instr3(); chk("reserved_acc", $signed(acc), -999); chk("reserved_pc", pc, 29);
    instr3(); chk("mov7_acc", $signed(acc), 7);
    instr3(); chk("mul_acc", $signed(acc), 21);
    instr3(); chk("not_acc", $signed(acc), -22);
    instr3(); chk("jmp_m1_pc", pc, 63);

    step(); run = 1'b0;
    step(); step(); chk("wrap_pc", pc, 0);
    step(); step(); chk("park_busy", busy, 0); chk("park_pc", pc, 0); chk("park_addr", prog_addr, 0);

    mem[0] = ins(4'd3, 10, 0);      // slp 10
    run = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("pre_rst_sleeping", sleeping, 1); chk("pre_rst_pc", pc, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_acc", $signed(acc), 0);
    chk("async_rst_pc", pc, 0);
    chk("async_rst_sleeping", sleeping, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_prog_addr", prog_addr, 0);
    step(); rst_n = 1'b1;
    step(); step();
    chk("resume_inst", alu_inst, 3); chk("resume_arg1", alu_arg1, 10); chk("resume_pc", pc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Upstream/downstream neighbour of the combinational 11-bit ALU.
- Fetches 26-bit instruction words from program memory and decodes them.
- Drives the ALU's inst/arg1/arg2/acc inputs, then writes the ALU result, clamped to [-999,+999], back into the accumulator.
- Owns the PC, the accumulator register, the jump logic and the sleep timer.

Parameters:
- PC_W, 6, program counter width; program depth is 2^PC_W words.
- SLP_W, 11, sleep counter width.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  fetch enable; when low, the FSM parks in FETCH after finishing the current instruction.
- prog_addr  out  PC_W  program memory read address.
- prog_data  in  26  instruction word, valid one cycle after prog_addr. Fields: [25:22] opcode, [21:11] arg1, [10:0] arg2.
- alu_inst  out  4  to ALU inst.
- alu_arg1  out  11  to ALU arg1.
- alu_arg2  out  11  to ALU arg2.
- alu_acc  out  11  to ALU acc; always equals acc.
- alu_out  in  11  ALU result (combinational, same cycle).
- acc  out  11  accumulator, signed.
- pc  out  PC_W  program counter.
- sleeping  out  1  high while in SLEEP.
- busy  out  1  high in any state other than FETCH.

Behaviour:
- Reset (async assert, sync release):
  - acc=0, pc=0, ir=0.
  - alu_inst=0, alu_arg1=0, alu_arg2=0.
  - sleeping=0, busy=0, state=FETCH, slp_cnt=0.
- States: FETCH -> DECODE -> EXEC -> (FETCH | SLEEP). Nominal cost is 3 cycles per instruction.
- FETCH:
  - prog_addr=pc.
  - If run=1, go to DECODE next cycle; otherwise stay in FETCH.
- DECODE:
  - ir <= prog_data.
  - Go to EXEC.
- EXEC (one cycle):
  - alu_inst=ir.opcode, alu_arg1=ir.arg1, alu_arg2=ir.arg2.
  - In all other states, alu_inst=0 and the ALU default passes acc through.
- Opcodes:
  - 0 nop: pc+1.
  - 1 mov: acc <= sat(arg1); pc+1.
  - 2 jmp: pc <= arg1[PC_W-1:0].
  - 3 slp: if arg1 is signed <=0, behave as nop. Otherwise slp_cnt <= arg1-1, pc+1, go to SLEEP.
  - 4 jez: if acc==0, pc <= arg1[PC_W-1:0]; else pc+1.
  - 5-8 (add/sub/mul/not): acc <= sat(alu_out); pc+1.
  - 9-15 reserved: treated as nop; acc unchanged.
- sat(x): signed 11-bit clamp. x > 999 gives 999; x < -999 gives -999; otherwise x unchanged.
- PC arithmetic: pc+1 wraps modulo 2^PC_W (last address to 0). Jump targets take the low PC_W bits of arg1; negative arg1 is truncated, not rejected.
- SLEEP:
  - sleeping=1.
  - Decrement slp_cnt each cycle.
  - When slp_cnt==0, go to FETCH next cycle.
  - slp N therefore occupies EXEC plus N SLEEP cycles.
  - run is ignored during SLEEP.
- run deassert mid-instruction: the instruction completes, and the FSM holds in FETCH until run=1.
- Reset mid-SLEEP or mid-EXEC: immediate return to reset values. No acc write occurs in that cycle.
- busy = (state != FETCH).

Test Plan:
- Reset then run=1; program: mov 5, add 3 (op5 arg1=3), nop -> acc=5 after 1st EXEC, acc=8 after 2nd, pc=3. Each instruction takes 3 cycles.
- mov 900; add 500 (ALU returns 1400 truncated to 11b, wrapping to -648) -> exercise sat on a stubbed ALU returning 999 and -1000. Required: acc=999 and acc=-999 respectively.
- jez loop: mov 0; jez 5 at addr 1 -> pc=5. Then mov 1; jez 0 -> pc increments, no jump.
- slp 4 -> sleeping=1 for exactly 4 cycles, busy=1 throughout, next prog_addr=pc+1. slp 0 and slp -3 -> no SLEEP state entered.
- PC wrap: nop at address 2^PC_W-1 -> pc=0. jmp -1 -> pc=2^PC_W-1.
- Assert rst_n=0 during SLEEP with slp_cnt=7 -> all outputs return to reset values asynchronously. After release, fetch resumes from pc=0.
